// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte image, assembles little-endian
// 32-bit words, writes them to instruction memory and releases the core only
// after the trailing XOR checksum byte matches.
module program_loader #(
    parameter int BIT_COUNT = 32,
    parameter int MAX_WORDS = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           RxData,
    input  logic                 RxValid,
    output logic                 RxReady,
    output logic                 MemWrite,
    output logic [3:0]           ByteEn,
    output logic [BIT_COUNT-1:0] MemAdr,
    output logic [31:0]          MemWriteData,
    output logic                 CoreReset,
    output logic                 Done,
    output logic                 Error
);

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } stateT;

    stateT       state, stateNext;
    logic [1:0]  byteCnt;
    logic [31:0] lenReg;
    logic [31:0] asmReg;
    logic [31:0] wordIdx;
    logic [7:0]  xorAcc;
    logic        accept;
    logic [31:0] lenWord;
    logic [31:0] dataWord;

    // Bytes arrive LSB first, so shifting in from the top leaves byte 0 in [7:0]
    // once all four have been taken.
    assign lenWord  = {RxData, lenReg[31:8]};
    assign dataWord = {RxData, asmReg[31:8]};
    assign accept   = RxValid && RxReady;
    assign ByteEn   = MemWrite ? 4'b1111 : 4'b0000;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= LEN;
        else       state <= stateNext;
    end

    // Next-state and state-decoded outputs; RxReady never looks at RxValid
    always_comb begin
        stateNext = state;
        RxReady   = 1'b0;
        CoreReset = 1'b1;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state)
            LEN: begin
                RxReady = !reset;
                if (accept && byteCnt == 2'd3) begin
                    if (lenWord > 32'(MAX_WORDS)) stateNext = ERROR;
                    else if (lenWord == 32'd0)    stateNext = CHECK;
                    else                          stateNext = DATA;
                end
            end
            DATA: begin
                RxReady = !reset;
                if (accept && byteCnt == 2'd3 && (wordIdx + 32'd1) == lenReg)
                    stateNext = CHECK;
            end
            CHECK: begin
                RxReady = !reset;
                if (accept) stateNext = (RxData == xorAcc) ? RUN : ERROR;
            end
            RUN: begin
                CoreReset = 1'b0;
                Done      = 1'b1;
            end
            ERROR: begin
                Error = 1'b1;
            end
            default: stateNext = LEN;
        endcase
    end

    // Byte assembly, running checksum and the registered one-cycle write port
    always_ff @(posedge clk) begin
        if (reset) begin
            byteCnt      <= 2'd0;
            lenReg       <= 32'd0;
            asmReg       <= 32'd0;
            wordIdx      <= 32'd0;
            xorAcc       <= 8'd0;
            MemWrite     <= 1'b0;
            MemAdr       <= '0;
            MemWriteData <= 32'd0;
        end else begin
            MemWrite <= 1'b0;
            if (accept) begin
                case (state)
                    LEN: begin
                        lenReg  <= lenWord;
                        byteCnt <= byteCnt + 2'd1;
                        xorAcc  <= xorAcc ^ RxData;
                        if (byteCnt == 2'd3) wordIdx <= 32'd0;
                    end
                    DATA: begin
                        asmReg  <= dataWord;
                        byteCnt <= byteCnt + 2'd1;
                        xorAcc  <= xorAcc ^ RxData;
                        if (byteCnt == 2'd3) begin
                            MemWrite     <= 1'b1;
                            MemWriteData <= dataWord;
                            MemAdr       <= BIT_COUNT'({wordIdx, 2'b00});
                            wordIdx      <= wordIdx + 32'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: valid, empty, bad-checksum, oversize,
// gapped, reset-mid-load and full-capacity images.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  RxData;
    logic        RxValid;
    logic        RxReady;
    logic        MemWrite;
    logic [3:0]  ByteEn;
    logic [31:0] MemAdr;
    logic [31:0] MemWriteData;
    logic        CoreReset;
    logic        Done;
    logic        Error;

    program_loader #(.BIT_COUNT(32), .MAX_WORDS(100)) dut (
        .clk(clk), .reset(reset), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .MemWrite(MemWrite), .ByteEn(ByteEn),
        .MemAdr(MemAdr), .MemWriteData(MemWriteData),
        .CoreReset(CoreReset), .Done(Done), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Write monitor: logs every strobe with the cycle it was seen in
    int          cyc = 0;
    logic        prevMw = 1'b0;
    logic        dblPulse = 1'b0;
    logic [31:0] wAdr[$];
    logic [31:0] wData[$];
    logic [3:0]  wBe[$];
    int          wCyc[$];

    always @(negedge clk) begin
        if (MemWrite) begin
            wAdr.push_back(MemAdr);
            wData.push_back(MemWriteData);
            wBe.push_back(ByteEn);
            wCyc.push_back(cyc + 1);
        end
        if (MemWrite && prevMw) dblPulse <= 1'b1;
        prevMw <= MemWrite;
        cyc    <= cyc + 1;
    end

    int drvCyc;
    int base;
    int d1;
    logic [7:0] vs [0:11];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte; it is taken on the following rising edge. gap>0 idles
    // RxValid for that many cycles afterwards.
    task automatic sendByte(input logic [7:0] b, input int gap);
        @(negedge clk); #1;
        RxData  = b;
        RxValid = 1'b1;
        drvCyc  = cyc;
        @(posedge clk);
        if (gap > 0) begin
            @(negedge clk); #1;
            RxValid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    // Step to the next sample point and stop offering bytes
    task automatic settle();
        @(negedge clk); #1;
        RxValid = 1'b0;
    endtask

    task automatic doReset(input logic chk);
        @(negedge clk); #1;
        reset   = 1'b1;
        RxValid = 1'b0;
        @(negedge clk); #1;
        if (chk) begin
            check("rst CoreReset", 32'(CoreReset), 32'd1);
            check("rst Done", 32'(Done), 32'd0);
            check("rst Error", 32'(Error), 32'd0);
            check("rst MemWrite", 32'(MemWrite), 32'd0);
            check("rst ByteEn", 32'(ByteEn), 32'd0);
            check("rst MemAdr", MemAdr, 32'd0);
            check("rst MemWriteData", MemWriteData, 32'd0);
            check("rst RxReady during reset", 32'(RxReady), 32'd0);
        end
        reset = 1'b0;
        #1;
        if (chk) check("RxReady after reset", 32'(RxReady), 32'd1);
    endtask

    // Sends the first n bytes of the valid 2-word image; d1 = drive cycle of byte 7
    task automatic sendValid(input int gap, input int n);
        for (int i = 0; i < n; i++) begin
            sendByte(vs[i], gap);
            if (i == 7) d1 = drvCyc;
        end
    endtask

    task automatic checkTwoWrites(input string tag);
        check({tag, " write count"}, 32'(wAdr.size() - base), 32'd2);
        if (wAdr.size() - base >= 2) begin
            check({tag, " adr0"}, wAdr[base], 32'h0);
            check({tag, " data0"}, wData[base], 32'h00500093);
            check({tag, " be0"}, 32'(wBe[base]), 32'hF);
            check({tag, " adr1"}, wAdr[base+1], 32'h4);
            check({tag, " data1"}, wData[base+1], 32'h00108113);
        end
    endtask

    initial begin
        logic [7:0] cs;
        reset   = 1'b1;
        RxValid = 1'b0;
        RxData  = 8'h00;
        vs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h81, 8'h10, 8'h00};
        repeat (2) @(negedge clk);

        // Valid 2-word load at full rate
        doReset(1'b1);
        base = wAdr.size();
        sendValid(0, 12);
        sendByte(8'h43, 0);
        settle();
        check("valid Done", 32'(Done), 32'd1);
        check("valid CoreReset", 32'(CoreReset), 32'd0);
        check("valid Error", 32'(Error), 32'd0);
        check("valid RxReady in RUN", 32'(RxReady), 32'd0);
        checkTwoWrites("valid");
        if (wCyc.size() - base >= 2) begin
            check("valid write0 latency", 32'(wCyc[base]), 32'(d1 + 1));
            check("valid write spacing", 32'(wCyc[base+1] - wCyc[base]), 32'd4);
        end

        // Zero length
        doReset(1'b0);
        base = wAdr.size();
        for (int i = 0; i < 4; i++) sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        settle();
        check("zero Done", 32'(Done), 32'd1);
        check("zero CoreReset", 32'(CoreReset), 32'd0);
        check("zero writes", 32'(wAdr.size() - base), 32'd0);

        // Bad checksum
        doReset(1'b0);
        base = wAdr.size();
        sendValid(0, 12);
        sendByte(8'h44, 0);
        settle();
        check("badcs Error", 32'(Error), 32'd1);
        check("badcs CoreReset", 32'(CoreReset), 32'd1);
        check("badcs Done", 32'(Done), 32'd0);
        check("badcs RxReady", 32'(RxReady), 32'd0);
        checkTwoWrites("badcs");
        sendByte(8'h55, 0);
        settle();
        check("badcs Error sticky", 32'(Error), 32'd1);
        check("badcs no extra write", 32'(wAdr.size() - base), 32'd2);

        // Oversize: 101 words
        doReset(1'b0);
        base = wAdr.size();
        sendByte(8'h65, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        settle();
        check("oversize Error", 32'(Error), 32'd1);
        check("oversize RxReady", 32'(RxReady), 32'd0);
        for (int i = 0; i < 8; i++) sendByte(8'h11, 0);
        settle();
        check("oversize Error sticky", 32'(Error), 32'd1);
        check("oversize no write", 32'(wAdr.size() - base), 32'd0);

        // Gaps of 3 idle cycles between every byte
        doReset(1'b0);
        base = wAdr.size();
        sendValid(3, 12);
        sendByte(8'h43, 3);
        check("gap Done", 32'(Done), 32'd1);
        check("gap CoreReset", 32'(CoreReset), 32'd0);
        checkTwoWrites("gap");

        // Reset after 6 data bytes, then replay
        doReset(1'b0);
        sendValid(0, 10);
        doReset(1'b1);
        check("midrst Done", 32'(Done), 32'd0);
        base = wAdr.size();
        sendValid(0, 12);
        sendByte(8'h43, 0);
        settle();
        check("midrst Done after replay", 32'(Done), 32'd1);
        checkTwoWrites("midrst");

        // Full capacity: 100 words, word k = k
        doReset(1'b0);
        base = wAdr.size();
        cs = 8'h64;
        sendByte(8'h64, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        for (int k = 0; k < 100; k++) begin
            sendByte(8'(k), 0);
            sendByte(8'h00, 0);
            sendByte(8'h00, 0);
            sendByte(8'h00, 0);
            cs = cs ^ 8'(k);
        end
        sendByte(cs, 0);
        settle();
        check("max Done", 32'(Done), 32'd1);
        check("max write count", 32'(wAdr.size() - base), 32'd100);
        if (wAdr.size() - base == 100) begin
            check("max last adr", wAdr[base+99], 32'h18C);
            check("max last data", wData[base+99], 32'd99);
            check("max spacing", 32'(wCyc[base+99] - wCyc[base]), 32'd396);
        end

        check("single-cycle write pulses", 32'(dblPulse), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
